// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: captures one LSU result, writes the GPR in WRITE, then retires it to the IFU in COMMIT.
// Optional retire counter enabled by defining YSYX_25060170_WBU_RETIRE_CNT_EN.
module ysyx_25060170_wbu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_load,
  input  logic [XLEN-1:0] in_csr,
  input  logic [2:0]      in_ld_type,
  input  logic [1:0]      in_addr_lo,
  output logic            GPR_we,
  output logic [4:0]      GPR_writer,
  output logic [XLEN-1:0] GPR_wd,
  output logic            commit_valid,
  input  logic            commit_ready,
  output logic [XLEN-1:0] commit_pc,
`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
  output logic [63:0]     retire_cnt,
`endif
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the sender holds its payload stable until then, and ready never depends on valid.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] r_pc, r_alu, r_load, r_csr;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic [1:0]      r_wb_sel;
  logic [2:0]      r_ld_type;
  logic [1:0]      r_addr_lo;

  logic            accept;
  logic [XLEN-1:0] ld_sh;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] wd;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_COMMIT;
      S_COMMIT: if (commit_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= '0;
      r_alu     <= '0;
      r_load    <= '0;
      r_csr     <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_wb_sel  <= '0;
      r_ld_type <= '0;
      r_addr_lo <= '0;
    end else if (accept) begin
      r_pc      <= in_pc;
      r_alu     <= in_alu;
      r_load    <= in_load;
      r_csr     <= in_csr;
      r_rd      <= in_rd;
      r_rd_we   <= in_rd_we;
      r_wb_sel  <= in_wb_sel;
      r_ld_type <= in_ld_type;
      r_addr_lo <= in_addr_lo;
    end
  end

  // Sub-word loads arrive word-aligned; bring the addressed byte/half down to bit 0.
  assign ld_sh = r_load >> {r_addr_lo, 3'b000};

  always_comb begin
    ld_data = '0;
    case (r_ld_type)
      3'b000:  ld_data = {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_data = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      3'b010:  ld_data = r_load;
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_sh[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_sh[15:0]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    wd = '0;
    case (r_wb_sel)
      2'b00:   wd = r_alu;
      2'b01:   wd = ld_data;
      2'b10:   wd = r_pc + XLEN'(4);
      2'b11:   wd = r_csr;
      default: wd = '0;
    endcase
  end

  always_comb begin
    GPR_we       = 1'b0;
    GPR_writer   = '0;
    GPR_wd       = '0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    if (state == S_WRITE) begin
      GPR_we     = r_rd_we && (r_rd != 5'd0);
      GPR_writer = r_rd;
      GPR_wd     = wd;
    end
    if (state == S_COMMIT) begin
      commit_valid = 1'b1;
      commit_pc    = r_pc;
    end
  end

`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (state == S_COMMIT && commit_ready) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Directed bench for ysyx_25060170_wbu: ALU/load/CSR/pc+4 write data, x0 suppression,
// commit backpressure, reset mid-flight and (with YSYX_25060170_WBU_RETIRE_CNT_EN) the retire counter.
module tb_ysyx_25060170_wbu;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_load;
  logic [XLEN-1:0] in_csr;
  logic [2:0]      in_ld_type;
  logic [1:0]      in_addr_lo;
  logic            GPR_we;
  logic [4:0]      GPR_writer;
  logic [XLEN-1:0] GPR_wd;
  logic            commit_valid;
  logic            commit_ready;
  logic [XLEN-1:0] commit_pc;
  logic [1:0]      dbg_state;
`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
  logic [63:0]     retire_cnt;
  logic [63:0]     exp_cnt;
`endif

  int checks;
  int errors;

  ysyx_25060170_wbu #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .in_wb_sel    (in_wb_sel),
    .in_alu       (in_alu),
    .in_load      (in_load),
    .in_csr       (in_csr),
    .in_ld_type   (in_ld_type),
    .in_addr_lo   (in_addr_lo),
    .GPR_we       (GPR_we),
    .GPR_writer   (GPR_writer),
    .GPR_wd       (GPR_wd),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_pc    (commit_pc),
`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
    .retire_cnt   (retire_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction at a negedge; returns at the negedge after the WRITE cycle (in COMMIT).
  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] load,
                       input logic [31:0] csr, input logic [2:0] ldt, input logic [1:0] alo,
                       input logic exp_we, input logic [31:0] exp_wd, input string tag);
    in_pc = pc; in_rd = rd; in_rd_we = we; in_wb_sel = sel;
    in_alu = alu; in_load = load; in_csr = csr; in_ld_type = ldt; in_addr_lo = alo;
    in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".we"}, {63'd0, GPR_we}, {63'd0, exp_we});
    chk({tag, ".writer"}, {59'd0, GPR_writer}, {59'd0, rd});
    if (exp_we) chk({tag, ".wd"}, {32'd0, GPR_wd}, {32'd0, exp_wd});
    chk({tag, ".cv_in_write"}, {63'd0, commit_valid}, 64'd0);
    @(negedge clk);
    chk({tag, ".cv"}, {63'd0, commit_valid}, 64'd1);
    chk({tag, ".cpc"}, {32'd0, commit_pc}, {32'd0, pc});
    chk({tag, ".we_off"}, {63'd0, GPR_we}, 64'd0);
  endtask

  // Instruction with commit_ready already high: handshake on the next edge, back to IDLE.
  task automatic run(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                     input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] load,
                     input logic [31:0] csr, input logic [2:0] ldt, input logic [1:0] alo,
                     input logic exp_we, input logic [31:0] exp_wd, input string tag);
    issue(pc, rd, we, sel, alu, load, csr, ldt, alo, exp_we, exp_wd, tag);
    @(negedge clk);
`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
    exp_cnt++;
`endif
    chk({tag, ".idle_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, ".idle_cv"}, {63'd0, commit_valid}, 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; in_valid = 1'b0; commit_ready = 1'b1;
    in_pc = '0; in_rd = '0; in_rd_we = 1'b0; in_wb_sel = '0;
    in_alu = '0; in_load = '0; in_csr = '0; in_ld_type = '0; in_addr_lo = '0;
`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
    exp_cnt = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst.we", {63'd0, GPR_we}, 64'd0);
    chk("rst.writer", {59'd0, GPR_writer}, 64'd0);
    chk("rst.wd", {32'd0, GPR_wd}, 64'd0);
    chk("rst.cv", {63'd0, commit_valid}, 64'd0);
    chk("rst.cpc", {32'd0, commit_pc}, 64'd0);
    chk("rst.state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // ALU, loads, CSR, pc+4 wrap
    run(32'h8000_0000, 5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h0000_1234, "alu");
    run(32'h8000_0004, 5'd10, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b000, 2'd2, 1'b1, 32'hFFFF_FFFF, "lb");
    run(32'h8000_0008, 5'd11, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b100, 2'd2, 1'b1, 32'h0000_00FF, "lbu");
    run(32'h8000_000C, 5'd12, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b001, 2'd0, 1'b1, 32'h0000_7F01, "lh");
    run(32'h8000_0010, 5'd13, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b010, 2'd0, 1'b1, 32'h80FF_7F01, "lw");
    run(32'h8000_0014, 5'd14, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b101, 2'd2, 1'b1, 32'h0000_80FF, "lhu");
    run(32'h8000_0018, 5'd15, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b001, 2'd2, 1'b1, 32'hFFFF_80FF, "lh_hi");
    run(32'h8000_001C, 5'd16, 1'b1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 3'b011, 2'd0, 1'b1, 32'h0000_0000, "ld_bad");
    run(32'h8000_0020, 5'd17, 1'b1, 2'b11, 32'h1, 32'h2, 32'hCAFE_F00D, 3'b000, 2'd0, 1'b1, 32'hCAFE_F00D, "csr");
    run(32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h0000_0000, "pc4_wrap");

    // x0 and rd_we=0: no GPR write, commit still happens
    run(32'h8000_0024, 5'd0, 1'b1, 2'b00, 32'hDEAD, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0, 32'h0, "x0");
    run(32'h8000_0028, 5'd7, 1'b0, 2'b00, 32'hBEEF, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0, 32'h0, "no_we");

    // commit backpressure; a second in_valid during the stall must be ignored
    commit_ready = 1'b0;
    issue(32'h8000_0100, 5'd3, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h55, "bp");
    in_valid = 1'b1; in_pc = 32'h9999_0000; in_alu = 32'h77;
    for (int i = 0; i < 4; i++) begin
      chk("bp.cv_hold", {63'd0, commit_valid}, 64'd1);
      chk("bp.cpc_hold", {32'd0, commit_pc}, 64'h8000_0100);
      chk("bp.in_ready_low", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    commit_ready = 1'b1;
    @(negedge clk);
`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
    exp_cnt++;
`endif
    chk("bp.after_ready", {63'd0, in_ready}, 64'd1);
    chk("bp.after_cv", {63'd0, commit_valid}, 64'd0);
    @(negedge clk);
    chk("bp.no_ghost_we", {63'd0, GPR_we}, 64'd0);
    chk("bp.still_idle", {62'd0, dbg_state}, 64'd0);

`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
    chk("cnt.before_reset", retire_cnt, exp_cnt);
`endif

    // reset while in WRITE
    in_pc = 32'h8000_0200; in_rd = 5'd9; in_rd_we = 1'b1; in_wb_sel = 2'b00; in_alu = 32'hABCD;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rstw.we_before", {63'd0, GPR_we}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rstw.we_drop", {63'd0, GPR_we}, 64'd0);
    chk("rstw.wd_drop", {32'd0, GPR_wd}, 64'd0);
    chk("rstw.in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstw.no_commit", {63'd0, commit_valid}, 64'd0);
      chk("rstw.no_we", {63'd0, GPR_we}, 64'd0);
    end

`ifdef YSYX_25060170_WBU_RETIRE_CNT_EN
    exp_cnt = 0;
    chk("cnt.reset", retire_cnt, exp_cnt);
    run(32'h1000, 5'd1, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h1, "cnt1");
    run(32'h1004, 5'd2, 1'b1, 2'b00, 32'h2, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h2, "cnt2");
    run(32'h1008, 5'd3, 1'b1, 2'b00, 32'h3, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h3, "cnt3");
    chk("cnt.three", retire_cnt, 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_25060170_wbu.md
YSYX_25060170_WBU -- requirements
Module: ysyx_25060170_WBU

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  upstream (LSU) result valid.
REQ-005 SHALL have port in_ready  out  1  block can accept a result.
REQ-006 SHALL have port in_pc  in  XLEN  PC of the instruction.
REQ-007 SHALL have port in_rd  in  5  destination register index.
REQ-008 SHALL have port in_rd_we  in  1  instruction writes rd.
REQ-009 SHALL have port in_wb_sel  in  2  source: 00 ALU, 01 load, 10 pc+4, 11 CSR.
REQ-010 SHALL have ports in_alu, in_load, in_csr  in  XLEN each  candidate write data.
REQ-011 SHALL have port in_ld_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 SHALL have port in_addr_lo  in  2  load byte address bits [1:0].
REQ-013 SHALL have ports GPR_we out 1, GPR_writer out 5, GPR_wd out XLEN  register-file write port.
REQ-014 SHALL have ports commit_valid out 1, commit_ready in 1, commit_pc out XLEN  retire handshake to IFU.

Function
REQ-015 SHALL run FSM IDLE -> WRITE -> COMMIT -> IDLE; in_ready = (state == IDLE), combinational.
REQ-016 SHALL capture all in_* fields into registers on in_valid && in_ready, and go to WRITE next cycle.
REQ-017 SHALL in WRITE assert GPR_we for exactly one cycle iff captured rd_we = 1 and rd != 0, then go to COMMIT unconditionally.
REQ-018 SHALL drive GPR_writer and GPR_wd from captured values in WRITE; both SHALL be 0 in other states.
REQ-019 SHALL compute write data from captured in_wb_sel: ALU = in_alu, CSR = in_csr, pc+4 = in_pc + 4 modulo 2^XLEN.
REQ-020 SHALL for loads shift in_load right by 8*in_addr_lo, then: LB sign-extend [7:0], LBU zero-extend [7:0], LH sign-extend [15:0], LHU zero-extend [15:0]; LW uses in_load unshifted; other funct3 codes yield 0.
REQ-021 SHALL in COMMIT hold commit_valid = 1 and commit_pc = captured pc, stable, until commit_ready = 1; return to IDLE the cycle after the handshake.
REQ-022 SHALL ignore in_valid outside IDLE; upstream holds data until in_ready.
REQ-023 SHALL give latency acceptance edge N -> GPR_we high in cycle N+1 -> commit_valid high from cycle N+2; min 3 cycles per instruction.
REQ-024 SHALL ignore commit_ready outside COMMIT.

Reset
REQ-025 SHALL on rst low asynchronously force IDLE, all captured registers 0, GPR_we 0, GPR_writer 0, GPR_wd 0, commit_valid 0, commit_pc 0; in_ready = 1 while in reset.
REQ-026 SHALL discard an in-flight instruction on reset in WRITE or COMMIT; no GPR write and no commit after release.

Configuration
REQ-027 SHALL with YSYX_25060170_WBU_RETIRE_CNT_EN defined add port retire_cnt out 64, reset 0, incremented by 1 per commit handshake, wrapping at 2^64.
REQ-028 SHALL without YSYX_25060170_WBU_RETIRE_CNT_EN omit retire_cnt and its counter; all other behaviour identical.

Verification
REQ-029 SHALL cover ALU write: in_rd=5, wb_sel=00, in_alu=0x1234 -> GPR_we=1 one cycle, writer=5, wd=0x1234; commit_valid next cycle with commit_pc=in_pc.
REQ-030 SHALL cover loads: in_load=0x80FF7F01, addr_lo=2, LB -> wd=0xFFFFFFFF; LBU -> 0x000000FF; addr_lo=0 LH -> 0x00007F01; LW -> 0x80FF7F01.
REQ-031 SHALL cover x0/no-write: in_rd=0, rd_we=1, and in_rd=7, rd_we=0 -> GPR_we stays 0; commit still occurs.
REQ-032 SHALL cover commit backpressure: commit_ready low 4 cycles -> commit_valid/commit_pc stable, in_ready 0 throughout; handshake, then in_ready 1 next cycle.
REQ-033 SHALL cover pc+4 wrap: in_pc=0xFFFFFFFC, wb_sel=10 -> wd=0x00000000.
REQ-034 SHALL cover reset in WRITE -> GPR_we drops immediately, no commit_valid after release; with macro, retire_cnt counts 3 back-to-back commits as 3.
